// File: rtl/mem_line_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_line_if
// Purpose  : Request / write-data / read-response bundle for a line responder.
// Revision : 1.0  initial release
// ============================================================================
interface mem_line_if #(
  parameter int ADDR_BITS = 28
);
  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic [ADDR_BITS-1:0] mem_req_addr;
  logic                 mem_req_rw;
  logic                 mem_req_data_valid;
  logic                 mem_req_data_ready;
  logic [127:0]         mem_req_data_bits;
  logic [15:0]          mem_req_data_mask;
  logic                 mem_resp_valid;
  logic [127:0]         mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_rw,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_rw,
           mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );
endinterface
`default_nettype wire

// File: rtl/mem_line_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mem_line_responder
// Purpose  : Single-outstanding memory model: masked writes, 4-beat read bursts.
//            Optional MEM_RESP_GAP_EN inserts one idle cycle between beats.
// Revision : 1.0  initial release
// ============================================================================
module mem_line_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DEPTH_BITS = 12,
  parameter int LATENCY    = 4
) (
  input  wire logic  clk,
  input  wire logic  reset,
  mem_line_if.slave  bus
);

`ifdef MEM_RESP_GAP_EN
  localparam logic c_GAP = 1'b1;
`else
  localparam logic c_GAP = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WAIT  = 2'd2,
    S_BURST = 2'd3
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  logic [1:0]            r_beat, w_beat_nxt;
  logic                  r_gap, w_gap_nxt;
  logic [DEPTH_BITS-1:0] r_idx, w_idx_nxt;

  logic                  w_wr_en;
  logic [DEPTH_BITS-1:0] w_wr_idx;
  logic                  w_emit;

  logic [127:0] r_mem [2**DEPTH_BITS];

  // Address bits above the storage index alias by design.
  wire w_unused_addr = &{1'b0, bus.mem_req_addr[ADDR_BITS-1:DEPTH_BITS]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_beat  <= '0;
      r_gap   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_beat  <= w_beat_nxt;
      r_gap   <= w_gap_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_beat_nxt  = r_beat;
    w_gap_nxt   = r_gap;
    w_idx_nxt   = r_idx;
    w_wr_en     = 1'b0;
    w_wr_idx    = r_idx;
    w_emit      = 1'b0;
    bus.mem_req_ready      = 1'b0;
    bus.mem_req_data_ready = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.mem_req_ready      = 1'b1;
        bus.mem_req_data_ready = 1'b1;
        if (bus.mem_req_valid) begin
          w_idx_nxt = bus.mem_req_addr[DEPTH_BITS-1:0];
          if (bus.mem_req_rw) begin
            if (bus.mem_req_data_valid) begin
              w_wr_en  = 1'b1;
              w_wr_idx = bus.mem_req_addr[DEPTH_BITS-1:0];
            end else begin
              w_state_nxt = S_WDATA;
            end
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = 4'(LATENCY - 1);
            w_beat_nxt  = 2'd0;
            w_gap_nxt   = 1'b0;
          end
        end
      end

      S_WDATA: begin
        bus.mem_req_data_ready = 1'b1;
        if (bus.mem_req_data_valid) begin
          w_wr_en     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      // Counter reaching zero marks the cycle of beat 0 itself.
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_emit      = 1'b1;
          w_beat_nxt  = 2'd1;
          w_gap_nxt   = c_GAP;
          w_state_nxt = S_BURST;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end

      S_BURST: begin
        if (r_gap) begin
          w_gap_nxt = 1'b0;
        end else begin
          w_emit     = 1'b1;
          w_beat_nxt = r_beat + 2'd1;
          w_gap_nxt  = c_GAP;
          if (r_beat == 2'd3) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage is not reset; reset only blocks a write in its own cycle.
  always_ff @(posedge clk) begin
    if (w_wr_en && !reset) begin
      for (int i = 0; i < 16; i++) begin
        if (bus.mem_req_data_mask[i]) begin
          r_mem[w_wr_idx][8*i +: 8] <= bus.mem_req_data_bits[8*i +: 8];
        end
      end
    end
  end

  assign bus.mem_resp_valid = w_emit;
  assign bus.mem_resp_data  = w_emit ? r_mem[{r_idx[DEPTH_BITS-1:2], r_beat}] : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_line_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_line_responder
// Purpose  : Directed + randomized self-checking bench against an array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_line_responder;
  localparam int AB  = 28;
  localparam int DB  = 12;
  localparam int LAT = 4;
`ifdef MEM_RESP_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif
  localparam int STRIDE = GAP + 1;
  localparam int SPAN   = 3 * STRIDE + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_line_if #(.ADDR_BITS(AB)) bus();

  mem_line_responder #(.ADDR_BITS(AB), .DEPTH_BITS(DB), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [127:0] model [1<<DB];
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_rw         = 1'b0;
    bus.mem_req_addr       = '0;
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_data_bits  = '0;
    bus.mem_req_data_mask  = '0;
  endtask

  task automatic model_write(input logic [AB-1:0] addr, input logic [127:0] data, input logic [15:0] mask);
    logic [DB-1:0] idx;
    idx = addr[DB-1:0];
    for (int b = 0; b < 16; b++)
      if (mask[b]) model[idx][8*b +: 8] = data[8*b +: 8];
  endtask

  task automatic do_write(input logic [AB-1:0] addr, input logic [127:0] data, input logic [15:0] mask);
    bus.mem_req_valid      = 1'b1;
    bus.mem_req_rw         = 1'b1;
    bus.mem_req_addr       = addr;
    bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits  = data;
    bus.mem_req_data_mask  = mask;
    check("wr_ready", bus.mem_req_ready, 1);
    step();
    model_write(addr, data, mask);
    idle_bus();
    check("wr_no_resp", bus.mem_resp_valid, 0);
    check("wr_back_idle", bus.mem_req_ready, 1);
  endtask

  task automatic split_write(input logic [AB-1:0] addr, input logic [127:0] data,
                             input logic [15:0] mask, input int delay);
    logic [AB-1:0] junk;
    bus.mem_req_valid      = 1'b1;
    bus.mem_req_rw         = 1'b1;
    bus.mem_req_addr       = addr;
    bus.mem_req_data_valid = 1'b0;
    bus.mem_req_data_bits  = ~data;
    bus.mem_req_data_mask  = 16'hFFFF;
    check("sw_ready_T", bus.mem_req_ready, 1);
    step();
    bus.mem_req_valid = 1'b0;
    junk = AB'($urandom);
    bus.mem_req_addr = junk;
    for (int j = 1; j < delay; j++) begin
      check("sw_busy", bus.mem_req_ready, 0);
      check("sw_dready", bus.mem_req_data_ready, 1);
      step();
    end
    check("sw_busy_last", bus.mem_req_ready, 0);
    bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits  = data;
    bus.mem_req_data_mask  = mask;
    step();
    model_write(addr, data, mask);
    idle_bus();
    check("sw_ready_after", bus.mem_req_ready, 1);
    check("sw_no_resp", bus.mem_resp_valid, 0);
  endtask

  task automatic do_read(input logic [AB-1:0] addr, input bit hold,
                         output int beats, output logic [127:0] beat0);
    logic [DB-1:0] idx;
    int rel;
    bit expv;
    logic [127:0] expd;
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = addr;
    check("rd_ready_T", bus.mem_req_ready, 1);
    beats = 0;
    beat0 = '0;
    for (int c = 1; c <= LAT + SPAN; c++) begin
      step();
      if (!hold) bus.mem_req_valid = 1'b0;
      rel  = c - LAT;
      expv = (rel >= 0) && (rel < SPAN) && (rel % STRIDE == 0);
      idx  = addr[DB-1:0];
      if (rel >= 0) idx[1:0] = 2'(rel / STRIDE);
      expd = expv ? model[idx] : 128'd0;
      check("rd_valid", bus.mem_resp_valid, expv);
      check("rd_data", bus.mem_resp_data, expd);
      check("rd_req_ready", bus.mem_req_ready, c >= LAT + SPAN);
      if (bus.mem_resp_valid) beats++;
      if (rel == 0) beat0 = bus.mem_resp_data;
    end
    idle_bus();
  endtask

  initial begin
    logic [AB-1:0]  a;
    logic [127:0]   d;
    logic [15:0]    m;
    logic [127:0]   b0;
    int             nb;
    int             op;

    idle_bus();
    reset = 1'b1;
    repeat (3) step();
    check("rst_req_ready", bus.mem_req_ready, 1);
    check("rst_data_ready", bus.mem_req_data_ready, 1);
    check("rst_resp_valid", bus.mem_resp_valid, 0);
    check("rst_resp_data", bus.mem_resp_data, 0);
    reset = 1'b0;
    step();

    // Known contents for every entry the bench will read, written via aliased addresses.
    for (int i = 0; i < 64; i++) begin
      a = AB'($urandom);
      a[DB-1:0] = DB'(i);
      d = {$urandom, $urandom, $urandom, $urandom};
      do_write(a, d, 16'hFFFF);
    end

    do_write(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF);
    do_read(28'h10, 1'b0, nb, b0);
    check("wr_rd_beat0", b0, 128'h0123456789ABCDEF0123456789ABCDEF);
    check("wr_rd_beats", nb, 4);

    do_write(28'h20, {128{1'b1}}, 16'hFFFF);
    do_write(28'h20, 128'd0, 16'h000F);
    do_read(28'h20, 1'b0, nb, b0);
    check("mask_beat0", b0, {{96{1'b1}}, 32'd0});

    split_write(28'h31, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 16'hFFFF, 3);
    do_read(28'h33, 1'b0, nb, b0);

    do_read(28'h0ABC_000 | 28'h16, 1'b1, nb, b0);
    check("stall_beats", nb, 4);

    // Reset during beat 1 aborts the burst.
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b0;
    bus.mem_req_addr  = 28'h8;
    for (int c = 1; c <= LAT + STRIDE; c++) begin
      step();
      bus.mem_req_valid = 1'b0;
    end
    check("rstb_beat1_valid", bus.mem_resp_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_bus();
    check("rstb_valid", bus.mem_resp_valid, 0);
    check("rstb_data", bus.mem_resp_data, 0);
    check("rstb_ready", bus.mem_req_ready, 1);
    check("rstb_dready", bus.mem_req_data_ready, 1);
    for (int j = 0; j < SPAN; j++) begin
      step();
      check("rstb_quiet", bus.mem_resp_valid, 0);
    end

    // Reset in WDATA drops the pending write.
    bus.mem_req_valid = 1'b1;
    bus.mem_req_rw    = 1'b1;
    bus.mem_req_addr  = 28'h25;
    step();
    bus.mem_req_valid      = 1'b0;
    bus.mem_req_data_valid = 1'b1;
    bus.mem_req_data_bits  = 128'h5555;
    bus.mem_req_data_mask  = 16'hFFFF;
    reset = 1'b1;
    step();
    reset = 1'b0;
    idle_bus();
    check("rstw_ready", bus.mem_req_ready, 1);
    do_read(28'h25, 1'b0, nb, b0);

    for (int n = 0; n < 30; n++) begin
      a = AB'($urandom);
      a[DB-1:6] = '0;
      d = {$urandom, $urandom, $urandom, $urandom};
      m = 16'($urandom);
      op = int'($urandom_range(0, 2));
      if (op == 0)      do_write(a, d, m);
      else if (op == 1) split_write(a, d, m, int'($urandom_range(1, 4)));
      else begin
        do_read(a, 1'($urandom), nb, b0);
        check("rand_beats", nb, 4);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
